// File: rtl/mem_ctrl_arbiter_if.sv
// Cache-side request/response and main-memory port signals of mem_ctrl_arbiter.
// The arbiter takes the slave view; caches plus memory model take the master view.
interface mem_ctrl_arbiter_if #(
    parameter int BLOCK_ADDR_W = 26,
    parameter int BLOCK_DATA_W = 256
) ();
    logic                    icache_req_valid;
    logic                    icache_req_type;
    logic [BLOCK_ADDR_W-1:0] icache_req_block_addr;
    logic                    icache_req_ready;
    logic                    icache_resp_valid;
    logic [BLOCK_DATA_W-1:0] icache_resp_block_data;

    logic                    dcache_req_valid;
    logic                    dcache_req_type;
    logic [BLOCK_ADDR_W-1:0] dcache_req_block_addr;
    logic [BLOCK_DATA_W-1:0] dcache_req_block_data;
    logic                    dcache_req_ready;
    logic                    dcache_resp_valid;
    logic [BLOCK_DATA_W-1:0] dcache_resp_block_data;

    logic                    mm_en;
    logic                    mm_we;
    logic [BLOCK_ADDR_W-1:0] mm_addr;
    logic [BLOCK_DATA_W-1:0] mm_wr_data;
    logic [BLOCK_DATA_W-1:0] mm_rd_data;

    modport slave (
        input  icache_req_valid, icache_req_type, icache_req_block_addr,
        output icache_req_ready, icache_resp_valid, icache_resp_block_data,
        input  dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
        output dcache_req_ready, dcache_resp_valid, dcache_resp_block_data,
        output mm_en, mm_we, mm_addr, mm_wr_data,
        input  mm_rd_data
    );

    modport master (
        output icache_req_valid, icache_req_type, icache_req_block_addr,
        input  icache_req_ready, icache_resp_valid, icache_resp_block_data,
        output dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
        input  dcache_req_ready, dcache_resp_valid, dcache_resp_block_data,
        input  mm_en, mm_we, mm_addr, mm_wr_data,
        output mm_rd_data
    );
endinterface

// File: rtl/mem_ctrl_arbiter.sv
// Arbitrates icache/dcache block requests onto one main-memory port with fixed latency.
// Optional macro MEM_CTRL_RR_ARB_EN replaces fixed icache priority with round-robin.
module mem_ctrl_arbiter #(
    parameter int BLOCK_ADDR_W = 26,
    parameter int BLOCK_DATA_W = 256,
    parameter int MEM_LATENCY  = 4
) (
    input  logic clk,
    input  logic rst_aH,
    input  logic flush,
    mem_ctrl_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state;
    logic                    owner;
    logic                    req_type;
    logic [BLOCK_ADDR_W-1:0] addr;
    logic [BLOCK_DATA_W-1:0] data;
    logic [7:0]              cnt;
    logic                    squash;

    logic ic_acc;
    logic dc_acc;
    logic access;

`ifdef MEM_CTRL_RR_ARB_EN
    logic last_grant;

    // On conflict the requester that was not granted last time wins.
    assign ic_acc = (state == IDLE) && !rst_aH && bus.icache_req_valid &&
                    (!bus.dcache_req_valid || last_grant);
    assign dc_acc = (state == IDLE) && !rst_aH && bus.dcache_req_valid &&
                    (!bus.icache_req_valid || !last_grant);

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            last_grant <= 1'b0;
        end else if (ic_acc) begin
            last_grant <= 1'b0;
        end else if (dc_acc) begin
            last_grant <= 1'b1;
        end
    end
`else
    assign ic_acc = (state == IDLE) && !rst_aH && bus.icache_req_valid;
    assign dc_acc = (state == IDLE) && !rst_aH && bus.dcache_req_valid && !bus.icache_req_valid;
`endif

    assign access = (state == BUSY) && (cnt == 8'd0);

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            state    <= IDLE;
            owner    <= 1'b0;
            req_type <= 1'b0;
            addr     <= '0;
            data     <= '0;
            cnt      <= 8'd0;
            squash   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ic_acc) begin
                        owner    <= 1'b0;
                        req_type <= 1'b0;
                        addr     <= bus.icache_req_block_addr;
                        data     <= '0;
                        cnt      <= 8'(MEM_LATENCY - 1);
                        squash   <= flush;
                        state    <= BUSY;
                    end else if (dc_acc) begin
                        owner    <= 1'b1;
                        req_type <= bus.dcache_req_type;
                        addr     <= bus.dcache_req_block_addr;
                        data     <= bus.dcache_req_block_data;
                        cnt      <= 8'(MEM_LATENCY - 1);
                        squash   <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                        if (flush && !owner) squash <= 1'b1;
                    end else begin
                        squash <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Everything memory-facing is zero outside the single access cycle.
    always_comb begin
        bus.icache_req_ready       = ic_acc;
        bus.dcache_req_ready       = dc_acc;
        bus.mm_en                  = 1'b0;
        bus.mm_we                  = 1'b0;
        bus.mm_addr                = '0;
        bus.mm_wr_data             = '0;
        bus.icache_resp_valid      = 1'b0;
        bus.icache_resp_block_data = '0;
        bus.dcache_resp_valid      = 1'b0;
        bus.dcache_resp_block_data = '0;
        if (access) begin
            bus.mm_en      = 1'b1;
            bus.mm_we      = req_type;
            bus.mm_addr    = addr;
            bus.mm_wr_data = data;
            if (!req_type) begin
                if (!owner) begin
                    bus.icache_resp_valid      = !squash && !flush;
                    bus.icache_resp_block_data = bus.mm_rd_data;
                end else begin
                    bus.dcache_resp_valid      = 1'b1;
                    bus.dcache_resp_block_data = bus.mm_rd_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Directed bench for mem_ctrl_arbiter: latency-4 instance plus a latency-1 instance.
module tb_mem_ctrl_arbiter;
    localparam int AW = 26;
    localparam int DW = 256;

    logic clk = 1'b0;
    logic rst_aH = 1'b1;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    localparam logic [DW-1:0] RD_A = {8{32'hDEADBEEF}};
    localparam logic [DW-1:0] RD_B = {8{32'h12345678}};
    localparam logic [DW-1:0] WB   = {32{8'hA5}};

    always #5 clk = ~clk;

    mem_ctrl_arbiter_if #(.BLOCK_ADDR_W(AW), .BLOCK_DATA_W(DW)) bus_a ();
    mem_ctrl_arbiter_if #(.BLOCK_ADDR_W(AW), .BLOCK_DATA_W(DW)) bus_b ();

    mem_ctrl_arbiter #(.BLOCK_ADDR_W(AW), .BLOCK_DATA_W(DW), .MEM_LATENCY(4)) dut_a (
        .clk(clk), .rst_aH(rst_aH), .flush(flush_a), .bus(bus_a.slave));
    mem_ctrl_arbiter #(.BLOCK_ADDR_W(AW), .BLOCK_DATA_W(DW), .MEM_LATENCY(1)) dut_b (
        .clk(clk), .rst_aH(rst_aH), .flush(flush_b), .bus(bus_b.slave));

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to 2 time units after the next rising edge (start of a new cycle).
    task automatic next();
        @(posedge clk);
        #2;
    endtask

    // Sample settled outputs 1 unit later, away from both edges.
    task automatic settle();
        #1;
    endtask

    task automatic idle_all();
        bus_a.icache_req_valid = 1'b0; bus_a.icache_req_type = 1'b0; bus_a.icache_req_block_addr = '0;
        bus_a.dcache_req_valid = 1'b0; bus_a.dcache_req_type = 1'b0; bus_a.dcache_req_block_addr = '0;
        bus_a.dcache_req_block_data = '0; bus_a.mm_rd_data = RD_A;
        bus_b.icache_req_valid = 1'b0; bus_b.icache_req_type = 1'b0; bus_b.icache_req_block_addr = '0;
        bus_b.dcache_req_valid = 1'b0; bus_b.dcache_req_type = 1'b0; bus_b.dcache_req_block_addr = '0;
        bus_b.dcache_req_block_data = '0; bus_b.mm_rd_data = RD_B;
    endtask

    initial begin
        idle_all();
        // Held in reset with requests pending: nothing may be granted.
        bus_a.icache_req_valid = 1'b1;
        bus_a.dcache_req_valid = 1'b1;
        #2; settle();
        chk("rst_ic_ready", DW'(bus_a.icache_req_ready), '0);
        chk("rst_dc_ready", DW'(bus_a.dcache_req_ready), '0);
        chk("rst_mm_en",    DW'(bus_a.mm_en), '0);
        chk("rst_mm_addr",  DW'(bus_a.mm_addr), '0);
        chk("rst_ic_resp",  DW'(bus_a.icache_resp_valid), '0);
        next();
        rst_aH = 1'b0;
        bus_a.dcache_req_valid = 1'b0;

        // c1: icache read 0x10
        bus_a.icache_req_block_addr = 26'h10;
        settle();
        chk("c1_ic_ready", DW'(bus_a.icache_req_ready), DW'(1));
        chk("c1_dc_ready", DW'(bus_a.dcache_req_ready), '0);
        next(); bus_a.icache_req_valid = 1'b0; settle();
        chk("c2_mm_en", DW'(bus_a.mm_en), '0);
        next(); next(); settle();
        chk("c4_mm_en", DW'(bus_a.mm_en), '0);
        next(); settle();
        chk("c5_mm_en",   DW'(bus_a.mm_en), DW'(1));
        chk("c5_mm_we",   DW'(bus_a.mm_we), '0);
        chk("c5_mm_addr", DW'(bus_a.mm_addr), DW'(26'h10));
        chk("c5_ic_resp", DW'(bus_a.icache_resp_valid), DW'(1));
        chk("c5_ic_data", bus_a.icache_resp_block_data, RD_A);
        chk("c5_dc_data", bus_a.dcache_resp_block_data, '0);

        // c6: dcache write 0x20, accepted immediately after the icache access
        next();
        bus_a.dcache_req_valid = 1'b1; bus_a.dcache_req_type = 1'b1;
        bus_a.dcache_req_block_addr = 26'h20; bus_a.dcache_req_block_data = WB;
        settle();
        chk("c6_dc_ready", DW'(bus_a.dcache_req_ready), DW'(1));
        chk("c6_mm_en",    DW'(bus_a.mm_en), '0);
        next(); bus_a.dcache_req_valid = 1'b0; settle();
        chk("c7_mm_wr",    bus_a.mm_wr_data, '0);
        next(); next(); next(); settle();
        chk("c10_mm_en",   DW'(bus_a.mm_en), DW'(1));
        chk("c10_mm_we",   DW'(bus_a.mm_we), DW'(1));
        chk("c10_mm_addr", DW'(bus_a.mm_addr), DW'(26'h20));
        chk("c10_mm_wr",   bus_a.mm_wr_data, WB);
        chk("c10_ic_resp", DW'(bus_a.icache_resp_valid), '0);
        chk("c10_dc_resp", DW'(bus_a.dcache_resp_valid), '0);

        // c11: conflict, icache 0x1 vs dcache read 0x2
        next();
        bus_a.icache_req_valid = 1'b1; bus_a.icache_req_block_addr = 26'h1;
        bus_a.dcache_req_valid = 1'b1; bus_a.dcache_req_type = 1'b0;
        bus_a.dcache_req_block_addr = 26'h2; bus_a.dcache_req_block_data = '0;
        settle();
        chk("c11_ic_ready", DW'(bus_a.icache_req_ready), DW'(1));
        chk("c11_dc_ready", DW'(bus_a.dcache_req_ready), '0);
        next(); bus_a.icache_req_valid = 1'b0; settle();
        chk("c12_dc_ready", DW'(bus_a.dcache_req_ready), '0);
        next(); next(); next(); settle();
        chk("c15_mm_addr", DW'(bus_a.mm_addr), DW'(26'h1));
        chk("c15_ic_resp", DW'(bus_a.icache_resp_valid), DW'(1));
        chk("c15_dc_ready", DW'(bus_a.dcache_req_ready), '0);
        next(); settle();
        chk("c16_dc_ready", DW'(bus_a.dcache_req_ready), DW'(1));
        next(); bus_a.dcache_req_valid = 1'b0;
        next(); next(); next(); settle();
        chk("c20_mm_en",   DW'(bus_a.mm_en), DW'(1));
        chk("c20_mm_addr", DW'(bus_a.mm_addr), DW'(26'h2));
        chk("c20_mm_we",   DW'(bus_a.mm_we), '0);
        chk("c20_dc_resp", DW'(bus_a.dcache_resp_valid), DW'(1));
        chk("c20_dc_data", bus_a.dcache_resp_block_data, RD_A);
        chk("c20_ic_data", bus_a.icache_resp_block_data, '0);

        // c21: icache read 0x30 with flush at c23 -> access but no response
        next();
        bus_a.icache_req_valid = 1'b1; bus_a.icache_req_block_addr = 26'h30;
        settle();
        chk("c21_ic_ready", DW'(bus_a.icache_req_ready), DW'(1));
        next(); bus_a.icache_req_valid = 1'b0;
        next(); flush_a = 1'b1;
        next(); flush_a = 1'b0;
        next(); settle();
        chk("c25_mm_en",   DW'(bus_a.mm_en), DW'(1));
        chk("c25_mm_addr", DW'(bus_a.mm_addr), DW'(26'h30));
        chk("c25_ic_resp", DW'(bus_a.icache_resp_valid), '0);

        // c26: dcache read 0x40 with flush at c28 -> response still delivered
        next();
        bus_a.dcache_req_valid = 1'b1; bus_a.dcache_req_type = 1'b0;
        bus_a.dcache_req_block_addr = 26'h40;
        settle();
        chk("c26_dc_ready", DW'(bus_a.dcache_req_ready), DW'(1));
        next(); bus_a.dcache_req_valid = 1'b0;
        next(); flush_a = 1'b1;
        next(); flush_a = 1'b0;
        next(); settle();
        chk("c30_dc_resp", DW'(bus_a.dcache_resp_valid), DW'(1));
        chk("c30_mm_addr", DW'(bus_a.mm_addr), DW'(26'h40));

        // c31: icache read 0x50, flush only during the access cycle c35
        next();
        bus_a.icache_req_valid = 1'b1; bus_a.icache_req_block_addr = 26'h50;
        next(); bus_a.icache_req_valid = 1'b0;
        next(); next(); next(); flush_a = 1'b1; settle();
        chk("c35_mm_en",   DW'(bus_a.mm_en), DW'(1));
        chk("c35_ic_resp", DW'(bus_a.icache_resp_valid), '0);

        // c36: dcache write 0x60, reset pulsed at c38
        next(); flush_a = 1'b0;
        bus_a.dcache_req_valid = 1'b1; bus_a.dcache_req_type = 1'b1;
        bus_a.dcache_req_block_addr = 26'h60; bus_a.dcache_req_block_data = WB;
        settle();
        chk("c36_dc_ready", DW'(bus_a.dcache_req_ready), DW'(1));
        next(); bus_a.dcache_req_valid = 1'b0;
        next(); rst_aH = 1'b1; settle();
        chk("c38_rst_en", DW'(bus_a.mm_en), '0);
        next(); settle();
        chk("c39_rst_we",   DW'(bus_a.mm_we), '0);
        chk("c39_rst_wr",   bus_a.mm_wr_data, '0);
        // c40: reset released; original access slot must stay silent, new request accepted
        next(); rst_aH = 1'b0;
        bus_a.icache_req_valid = 1'b1; bus_a.icache_req_block_addr = 26'h70;
        settle();
        chk("c40_mm_en",    DW'(bus_a.mm_en), '0);
        chk("c40_mm_we",    DW'(bus_a.mm_we), '0);
        chk("c40_ic_ready", DW'(bus_a.icache_req_ready), DW'(1));
        next(); bus_a.icache_req_valid = 1'b0;
        next(); next(); next(); settle();
        chk("c44_mm_addr", DW'(bus_a.mm_addr), DW'(26'h70));
        chk("c44_ic_resp", DW'(bus_a.icache_resp_valid), DW'(1));

        // Latency-1 instance: accept, respond next cycle, accept again the cycle after
        next();
        bus_b.icache_req_valid = 1'b1; bus_b.icache_req_block_addr = 26'h5;
        settle();
        chk("b1_ic_ready", DW'(bus_b.icache_req_ready), DW'(1));
        next(); bus_b.icache_req_valid = 1'b0;
        bus_b.dcache_req_valid = 1'b1; bus_b.dcache_req_type = 1'b0;
        bus_b.dcache_req_block_addr = 26'h6;
        settle();
        chk("b2_mm_en",    DW'(bus_b.mm_en), DW'(1));
        chk("b2_mm_addr",  DW'(bus_b.mm_addr), DW'(26'h5));
        chk("b2_ic_resp",  DW'(bus_b.icache_resp_valid), DW'(1));
        chk("b2_ic_data",  bus_b.icache_resp_block_data, RD_B);
        chk("b2_dc_ready", DW'(bus_b.dcache_req_ready), '0);
        next(); settle();
        chk("b3_dc_ready", DW'(bus_b.dcache_req_ready), DW'(1));
        chk("b3_mm_en",    DW'(bus_b.mm_en), '0);
        next(); bus_b.dcache_req_valid = 1'b0; settle();
        chk("b4_mm_addr",  DW'(bus_b.mm_addr), DW'(26'h6));
        chk("b4_dc_resp",  DW'(bus_b.dcache_resp_valid), DW'(1));
        chk("b4_dc_data",  bus_b.dcache_resp_block_data, RD_B);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
